y_edge_monitor: RTL and testbench



---
 rtl/y_edge_monitor.sv | 194 +++++++++++++++++++
 tb/tb_y_edge_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_edge_monitor.sv
// y_edge_monitor: clocked observation point for the asynchronous a/b/c/d logic result.
// The input is synchronised, then debounced by a four-state filter. The block
// reports single-cycle rise/fall pulses and keeps a saturating count of rising
// edges, with a sticky overflow flag.
module y_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 y_in,
    input  logic                 clr,
    output logic                 y_filt,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] rise_cnt,
    output logic                 cnt_ovf
);

    // Filter counter is wide enough to hold FILTER_LEN, although it never exceeds FILTER_LEN-1.
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    // With a one-cycle filter a new level is accepted on the first cycle it is seen.
    localparam bit DIRECT = (FILTER_LEN == 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   y_s;

    // First stage captures the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= y_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            // Each later stage shifts the previous one along the chain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign y_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Filter state machine
    // ------------------------------------------------------------------
    state_t         state_reg;
    logic [FW-1:0]  fcnt_reg;
    logic           y_filt_reg;
    logic           rise_pulse_reg;
    logic           fall_pulse_reg;
    logic           rise_event;
    logic           fall_event;

    // Decode the edges on which the filtered level will change, shared by the FSM and the counter.
    always_comb begin
        rise_event = 1'b0;
        fall_event = 1'b0;
        case (state_reg)
            ST_LO:   rise_event = y_s && DIRECT;
            CHK_HI:  rise_event = y_s && (fcnt_reg == FCNT_LAST);
            ST_HI:   fall_event = !y_s && DIRECT;
            CHK_LO:  fall_event = !y_s && (fcnt_reg == FCNT_LAST);
            default: begin
                rise_event = 1'b0;
                fall_event = 1'b0;
            end
        endcase
    end

    // Debounce FSM with registered level and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_LO;
            fcnt_reg       <= '0;
            y_filt_reg     <= 1'b0;
            rise_pulse_reg <= 1'b0;
            fall_pulse_reg <= 1'b0;
        end else begin
            rise_pulse_reg <= rise_event;
            fall_pulse_reg <= fall_event;
            case (state_reg)
                ST_LO: begin
                    if (y_s) begin
                        if (DIRECT) begin
                            state_reg  <= ST_HI;
                            y_filt_reg <= 1'b1;
                        end else begin
                            state_reg <= CHK_HI;
                            fcnt_reg  <= FCNT_ONE;
                        end
                    end
                end
                CHK_HI: begin
                    if (!y_s) begin
                        // Short high glitch: drop back without reporting anything.
                        state_reg <= ST_LO;
                        fcnt_reg  <= '0;
                    end else if (fcnt_reg == FCNT_LAST) begin
                        state_reg  <= ST_HI;
                        fcnt_reg   <= '0;
                        y_filt_reg <= 1'b1;
                    end else begin
                        fcnt_reg <= fcnt_reg + FCNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!y_s) begin
                        if (DIRECT) begin
                            state_reg  <= ST_LO;
                            y_filt_reg <= 1'b0;
                        end else begin
                            state_reg <= CHK_LO;
                            fcnt_reg  <= FCNT_ONE;
                        end
                    end
                end
                CHK_LO: begin
                    if (y_s) begin
                        // Short low glitch: return to the accepted high level.
                        state_reg <= ST_HI;
                        fcnt_reg  <= '0;
                    end else if (fcnt_reg == FCNT_LAST) begin
                        state_reg  <= ST_LO;
                        fcnt_reg   <= '0;
                        y_filt_reg <= 1'b0;
                    end else begin
                        fcnt_reg <= fcnt_reg + FCNT_ONE;
                    end
                end
                default: begin
                    state_reg  <= ST_LO;
                    fcnt_reg   <= '0;
                    y_filt_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rising-edge counter
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] rise_cnt_reg;
    logic                 cnt_ovf_reg;

    // Saturating count of accepted rises; a clear coinciding with a rise counts that rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt_reg <= '0;
            cnt_ovf_reg  <= 1'b0;
        end else if (rise_event) begin
            if (clr) begin
                rise_cnt_reg <= CNT_WIDTH'(1);
                cnt_ovf_reg  <= 1'b0;
            end else if (rise_cnt_reg == CNT_MAX) begin
                cnt_ovf_reg <= 1'b1;
            end else begin
                rise_cnt_reg <= rise_cnt_reg + CNT_WIDTH'(1);
            end
        end else if (clr) begin
            rise_cnt_reg <= '0;
            cnt_ovf_reg  <= 1'b0;
        end
    end

    assign y_filt     = y_filt_reg;
    assign rise_pulse = rise_pulse_reg;
    assign fall_pulse = fall_pulse_reg;
    assign rise_cnt   = rise_cnt_reg;
    assign cnt_ovf    = cnt_ovf_reg;

endmodule

// File: tb/tb_y_edge_monitor.sv
// Directed testbench for y_edge_monitor: default instance plus a fast
// (SYNC_STAGES=3, FILTER_LEN=1) instance for the minimum-filter case.
module tb_y_edge_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       y_in = 1'b0;
    logic       clr = 1'b0;
    logic       y_filt, rise_pulse, fall_pulse, cnt_ovf;
    logic [7:0] rise_cnt;

    logic       y_fast = 1'b0;
    logic       clr_fast = 1'b0;
    logic       f_filt, f_rise, f_fall, f_ovf;
    logic [7:0] f_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y_edge_monitor #(.SYNC_STAGES(2), .FILTER_LEN(4), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .y_in(y_in), .clr(clr),
        .y_filt(y_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rise_cnt(rise_cnt), .cnt_ovf(cnt_ovf)
    );

    y_edge_monitor #(.SYNC_STAGES(3), .FILTER_LEN(1), .CNT_WIDTH(8)) u_fast (
        .clk(clk), .rst(rst), .y_in(y_fast), .clr(clr_fast),
        .y_filt(f_filt), .rise_pulse(f_rise), .fall_pulse(f_fall),
        .rise_cnt(f_cnt), .cnt_ovf(f_ovf)
    );

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a full accepted rise followed by a full accepted fall (no checks).
    task automatic drive_pulse_train();
        y_in = 1'b1;
        repeat (6) tick();
        y_in = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        y_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({y_filt, rise_pulse, fall_pulse, rise_cnt, cnt_ovf} !== 12'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: got filt=%b rp=%b fp=%b cnt=%0d ovf=%b, want all 0",
                         i, y_filt, rise_pulse, fall_pulse, rise_cnt, cnt_ovf);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_vec++;
            if (y_filt !== 1'b0 || rise_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release edge%0d: got filt=%b rp=%b, want 0 0", i, y_filt, rise_pulse);
            end
        end
        tick();
        n_vec++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b1 || rise_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL first_rise: got filt=%b rp=%b cnt=%0d, want 1 1 1", y_filt, rise_pulse, rise_cnt);
        end
        tick();
        n_vec++;
        if (rise_pulse !== 1'b0 || y_filt !== 1'b1) begin
            n_err++;
            $display("FAIL rise_one_cycle: got rp=%b filt=%b, want 0 1", rise_pulse, y_filt);
        end
        y_in = 1'b0;
        repeat (6) tick();
        n_vec++;
        if (y_filt !== 1'b0 || fall_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL first_fall: got filt=%b fp=%b, want 0 1", y_filt, fall_pulse);
        end
        tick();
    endtask

    task automatic test_glitch();
        y_in = 1'b1;
        repeat (3) tick();
        y_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (y_filt !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || rise_cnt !== 8'd1) begin
                n_err++;
                $display("FAIL glitch_reject cyc%0d: got filt=%b rp=%b fp=%b cnt=%0d, want 0 0 0 1",
                         i, y_filt, rise_pulse, fall_pulse, rise_cnt);
            end
        end
        y_in = 1'b1;
        repeat (6) tick();
        n_vec++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b1 || rise_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL clean_rise: got filt=%b rp=%b cnt=%0d, want 1 1 2", y_filt, rise_pulse, rise_cnt);
        end
        y_in = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (y_filt !== 1'b1 || fall_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL fall_early: got filt=%b fp=%b, want 1 0", y_filt, fall_pulse);
        end
        tick();
        n_vec++;
        if (y_filt !== 1'b0 || fall_pulse !== 1'b1 || rise_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL clean_fall: got filt=%b fp=%b cnt=%0d, want 0 1 2", y_filt, fall_pulse, rise_cnt);
        end
        tick();
        n_vec++;
        if (fall_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL fall_one_cycle: got fp=%b, want 0", fall_pulse);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 255; i++) drive_pulse_train();
        n_vec++;
        if (rise_cnt !== 8'd255 || cnt_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sat_255: got cnt=%0d ovf=%b, want 255 0", rise_cnt, cnt_ovf);
        end
        drive_pulse_train();
        n_vec++;
        if (rise_cnt !== 8'd255 || cnt_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL sat_256: got cnt=%0d ovf=%b, want 255 1", rise_cnt, cnt_ovf);
        end
        drive_pulse_train();
        drive_pulse_train();
        n_vec++;
        if (rise_cnt !== 8'd255 || cnt_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL sat_hold: got cnt=%0d ovf=%b, want 255 1", rise_cnt, cnt_ovf);
        end
    endtask

    task automatic test_clr();
        y_in = 1'b1;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (rise_cnt !== 8'd1 || cnt_ovf !== 1'b0 || rise_pulse !== 1'b1 || y_filt !== 1'b1) begin
            n_err++;
            $display("FAIL clr_with_rise: got cnt=%0d ovf=%b rp=%b filt=%b, want 1 0 1 1",
                     rise_cnt, cnt_ovf, rise_pulse, y_filt);
        end
        y_in = 1'b0;
        repeat (8) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (rise_cnt !== 8'd0 || cnt_ovf !== 1'b0 || y_filt !== 1'b0) begin
            n_err++;
            $display("FAIL clr_alone: got cnt=%0d ovf=%b filt=%b, want 0 0 0", rise_cnt, cnt_ovf, y_filt);
        end
    endtask

    task automatic test_reset_mid_filter();
        drive_pulse_train();
        y_in = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({y_filt, rise_pulse, fall_pulse, rise_cnt, cnt_ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL mid_filter_rst: got filt=%b rp=%b fp=%b cnt=%0d ovf=%b, want all 0",
                     y_filt, rise_pulse, fall_pulse, rise_cnt, cnt_ovf);
        end
        repeat (5) tick();
        n_vec++;
        if (y_filt !== 1'b0) begin
            n_err++;
            $display("FAIL mid_filter_early: got filt=%b, want 0", y_filt);
        end
        tick();
        n_vec++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b1 || rise_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL mid_filter_rise: got filt=%b rp=%b cnt=%0d, want 1 1 1", y_filt, rise_pulse, rise_cnt);
        end
        y_in = 1'b0;
        repeat (7) tick();
    endtask

    task automatic test_fast_filter();
        logic [2:0] exp_filt [0:5];
        logic [2:0] got;
        // {y_filt, rise_pulse, fall_pulse} after each tick; single high sample at tick 1.
        exp_filt[0] = 3'b000;
        exp_filt[1] = 3'b000;
        exp_filt[2] = 3'b000;
        exp_filt[3] = 3'b110;
        exp_filt[4] = 3'b001;
        exp_filt[5] = 3'b000;
        y_fast = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            y_fast = 1'b0;
            got = {f_filt, f_rise, f_fall};
            n_vec++;
            if (got !== exp_filt[i]) begin
                n_err++;
                $display("FAIL fast_seq tick%0d: got filt/rp/fp=%b, want %b", i + 1, got, exp_filt[i]);
            end
        end
        n_vec++;
        if (f_cnt !== 8'd1 || f_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL fast_cnt: got cnt=%0d ovf=%b, want 1 0", f_cnt, f_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_saturation();
        test_clr();
        test_reset_mid_filter();
        test_fast_filter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
